oled_seq_ctrl: RTL

Sequencer that owns the shared `iic_driver` instance feeding the SSD1306 OLED at slave address 0x78. After reset it waits a power-up delay, then issues the fixed SSD1306 init command list. It then services full-frame refresh requests by streaming page-address commands and 1024 pixel bytes, read from an external framebuffer RAM, one `iic_driver` transaction at a time. It is the only block allowed to drive `iic_start`/`dc`/`din` of the driver.

---
 rtl/oled_pkg.sv | 32 +++
 rtl/oled_seq_ctrl_if.sv | 19 +
 rtl/oled_init_rom.sv | 40 ++++
 rtl/oled_seq_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared constants for the SSD1306 sequencer: FSM encoding, controller command bytes and init list length.
package oled_pkg;

  localparam logic [3:0] S_PWRUP      = 4'd0;
  localparam logic [3:0] S_INIT_ISSUE = 4'd1;
  localparam logic [3:0] S_INIT_WAIT  = 4'd2;
  localparam logic [3:0] S_IDLE       = 4'd3;
  localparam logic [3:0] S_PCMD_ISSUE = 4'd4;
  localparam logic [3:0] S_PCMD_WAIT  = 4'd5;
  localparam logic [3:0] S_FETCH      = 4'd6;
  localparam logic [3:0] S_DATA_ISSUE = 4'd7;
  localparam logic [3:0] S_DATA_WAIT  = 4'd8;

  localparam logic [7:0] SSD1306_ADDR = 8'h78;
  localparam logic [7:0] CTRL_CMD     = 8'h00;
  localparam logic [7:0] CTRL_DATA    = 8'h40;
  localparam logic [7:0] PCMD_PAGE    = 8'hB0;
  localparam logic [7:0] PCMD_COL_LO  = 8'h00;
  localparam logic [7:0] PCMD_COL_HI  = 8'h10;
  localparam logic [7:0] SSD1306_NOP  = 8'hE3;
  localparam int         INIT_LEN     = 25;

  // Per-page preamble: page select, then column pointer reset (low nibble, high nibble).
  function automatic logic [7:0] page_cmd(input logic [1:0] sub, input logic [2:0] page);
    case (sub)
      2'd0:    page_cmd = PCMD_PAGE | {5'd0, page};
      2'd1:    page_cmd = PCMD_COL_LO;
      default: page_cmd = PCMD_COL_HI;
    endcase
  endfunction

endpackage

// File: rtl/oled_seq_ctrl_if.sv
// Sequencer-to-driver handshake plus the framebuffer read port.
interface oled_seq_ctrl_if;
  logic       iic_start;
  logic       iic_dc;
  logic [7:0] iic_din;
  logic       iic_done;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;

  modport master (
    output iic_start, iic_dc, iic_din, fb_addr,
    input  iic_done, fb_data
  );

  modport slave (
    input  iic_start, iic_dc, iic_din, fb_addr,
    output iic_done, fb_data
  );
endinterface

// File: rtl/oled_init_rom.sv
// SSD1306 power-on command list, indexed combinationally; indices past the list read as NOP.
module oled_init_rom
  import oled_pkg::*;
(
  input  logic [4:0] idx_i,
  output logic [7:0] byte_o
);

  always_comb begin
    case (idx_i)
      5'd0:    byte_o = 8'hAE;
      5'd1:    byte_o = 8'hD5;
      5'd2:    byte_o = 8'h80;
      5'd3:    byte_o = 8'hA8;
      5'd4:    byte_o = 8'h3F;
      5'd5:    byte_o = 8'hD3;
      5'd6:    byte_o = 8'h00;
      5'd7:    byte_o = 8'h40;
      5'd8:    byte_o = 8'h8D;
      5'd9:    byte_o = 8'h14;
      5'd10:   byte_o = 8'h20;
      5'd11:   byte_o = 8'h02;
      5'd12:   byte_o = 8'hA1;
      5'd13:   byte_o = 8'hC8;
      5'd14:   byte_o = 8'hDA;
      5'd15:   byte_o = 8'h12;
      5'd16:   byte_o = 8'h81;
      5'd17:   byte_o = 8'hCF;
      5'd18:   byte_o = 8'hD9;
      5'd19:   byte_o = 8'hF1;
      5'd20:   byte_o = 8'hDB;
      5'd21:   byte_o = 8'h40;
      5'd22:   byte_o = 8'hA4;
      5'd23:   byte_o = 8'hA6;
      5'd24:   byte_o = 8'hAF;
      default: byte_o = SSD1306_NOP;
    endcase
  end

endmodule

// File: rtl/oled_seq_ctrl.sv
// Owns the iic_driver: power-up wait, SSD1306 init list, then full-frame refreshes from the framebuffer.
// One transaction in flight at a time; refresh requests collapse into a single pending flag.
module oled_seq_ctrl
  import oled_pkg::*;
#(
  parameter int PWRUP_WAIT = 1_000_000,
  parameter int PAGES      = 8,
  parameter int COLS       = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            refresh,
  output logic            busy,
  output logic            init_done,
  oled_seq_ctrl_if.master bus
);

  localparam int              PW_W      = (PWRUP_WAIT > 1) ? $clog2(PWRUP_WAIT) : 1;
  localparam logic [PW_W-1:0] PW_LAST   = PW_W'(PWRUP_WAIT - 1);
  localparam logic [4:0]      IDX_LAST  = 5'(INIT_LEN - 1);
  localparam logic [2:0]      PAGE_LAST = 3'(PAGES - 1);
  localparam logic [6:0]      COL_LAST  = 7'(COLS - 1);

  logic [3:0]      state_q, state_d;
  logic [PW_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [4:0]      idx_q, idx_d;
  logic [2:0]      page_q, page_d;
  logic [6:0]      col_q, col_d;
  logic [1:0]      sub_q, sub_d;
  logic            pending_q, pending_d;
  logic            init_done_q, init_done_d;
  logic [7:0]      din_q, din_d;
  logic [7:0]      rom_byte;

  oled_init_rom u_rom (
    .idx_i  (idx_q),
    .byte_o (rom_byte)
  );

  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    idx_d       = idx_q;
    page_d      = page_q;
    col_d       = col_q;
    sub_d       = sub_q;
    pending_d   = pending_q | refresh;
    init_done_d = init_done_q;
    din_d       = din_q;
    case (state_q)
      S_PWRUP: begin
        if (pwr_cnt_q == PW_LAST) begin
          pwr_cnt_d = '0;
          idx_d     = '0;
          state_d   = S_INIT_ISSUE;
        end else begin
          pwr_cnt_d = pwr_cnt_q + PW_W'(1);
        end
      end
      S_INIT_ISSUE: state_d = S_INIT_WAIT;
      S_INIT_WAIT: begin
        if (bus.iic_done) begin
          if (idx_q == IDX_LAST) begin
            idx_d       = '0;
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_INIT_ISSUE;
          end
        end
      end
      S_IDLE: begin
        // A refresh landing in this very cycle stays pending for a follow-up frame.
        if (pending_q) begin
          pending_d = refresh;
          page_d    = '0;
          sub_d     = '0;
          col_d     = '0;
          state_d   = S_PCMD_ISSUE;
        end
      end
      S_PCMD_ISSUE: state_d = S_PCMD_WAIT;
      S_PCMD_WAIT: begin
        if (bus.iic_done) begin
          if (sub_q == 2'd2) begin
            sub_d   = '0;
            col_d   = '0;
            state_d = S_FETCH;
          end else begin
            sub_d   = sub_q + 2'd1;
            state_d = S_PCMD_ISSUE;
          end
        end
      end
      S_FETCH: state_d = S_DATA_ISSUE;
      S_DATA_ISSUE: begin
        din_d   = bus.fb_data;
        state_d = S_DATA_WAIT;
      end
      S_DATA_WAIT: begin
        if (bus.iic_done) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (page_q == PAGE_LAST) begin
              page_d  = '0;
              state_d = S_IDLE;
            end else begin
              page_d  = page_q + 3'd1;
              state_d = S_PCMD_ISSUE;
            end
          end else begin
            col_d   = col_q + 7'd1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PWRUP;
      pwr_cnt_q   <= '0;
      idx_q       <= '0;
      page_q      <= '0;
      col_q       <= '0;
      sub_q       <= '0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      idx_q       <= idx_d;
      page_q      <= page_d;
      col_q       <= col_d;
      sub_q       <= sub_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      din_q       <= din_d;
    end
  end

  // Command bytes come straight from the counters, which only move on iic_done, so they hold
  // through the transaction; data is taken live from the RAM at issue and held in din_q after.
  always_comb begin
    bus.iic_start = 1'b0;
    bus.iic_dc    = 1'b0;
    bus.iic_din   = din_q;
    case (state_q)
      S_INIT_ISSUE: begin
        bus.iic_start = 1'b1;
        bus.iic_din   = rom_byte;
      end
      S_INIT_WAIT:  bus.iic_din = rom_byte;
      S_PCMD_ISSUE: begin
        bus.iic_start = 1'b1;
        bus.iic_din   = page_cmd(sub_q, page_q);
      end
      S_PCMD_WAIT:  bus.iic_din = page_cmd(sub_q, page_q);
      S_DATA_ISSUE: begin
        bus.iic_start = 1'b1;
        bus.iic_dc    = 1'b1;
        bus.iic_din   = bus.fb_data;
      end
      S_DATA_WAIT:  bus.iic_dc = 1'b1;
      default: ;
    endcase
  end

  assign bus.fb_addr = 10'(page_q) * 10'(COLS) + 10'(col_q);
  assign busy        = (state_q != S_IDLE) | pending_q;
  assign init_done   = init_done_q;

endmodule
